// File: rtl/task_dispatcher.sv
// task_dispatcher: buffers host tasks, feeds the Othello solver slots,
// flushes stale slots after reset and collects real results.
// Ports: iCLOCK/iRESET; in_* host task stream (valid/ready);
// pl_* presented task, enable and solve report; res_* result stream
// (valid/ready); busy, inflight, cnt_accepted, cnt_done status.
module task_dispatcher #(
  parameter int SLOTS  = 8,
  parameter int IDW    = 16,
  parameter int QDEPTH = 16,
  parameter int RDEPTH = 8,
  parameter int CW     = 32,
  localparam int PIW   = $clog2(SLOTS)
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_player,
  input  logic [63:0]       in_opponent,
  input  logic [IDW-1:0]    in_taskid,
  output logic              pl_enable,
  output logic [63:0]       pl_player,
  output logic [63:0]       pl_opponent,
  output logic [IDW-1:0]    pl_taskid,
  input  logic              pl_solved,
  input  logic [IDW-1:0]    pl_taskid_o,
  input  logic [63:0]       pl_player_o,
  input  logic [63:0]       pl_opponent_o,
  input  logic signed [7:0] pl_res,
  input  logic [PIW-1:0]    pl_pidx,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_taskid,
  output logic [63:0]       res_player,
  output logic [63:0]       res_opponent,
  output logic signed [7:0] res_score,
  output logic              busy,
  output logic [PIW:0]      inflight,
  output logic [CW-1:0]     cnt_accepted,
  output logic [CW-1:0]     cnt_done
);

  localparam int QAW = $clog2(QDEPTH);
  localparam int RAW = $clog2(RDEPTH);

  localparam logic [IDW-1:0]   DUMMY_ID = '1;
  localparam logic [QAW:0]     IQ_ONE   = 1;
  localparam logic [RAW:0]     RQ_ONE   = 1;
  localparam logic [CW-1:0]    CNT_ONE  = 1;
  localparam logic [PIW:0]     IF_ONE   = 1;
  localparam logic [SLOTS-1:0] SEEN_ONE = 1;

  typedef enum logic {
    S_FLUSH,
    S_RUN
  } state_t;

  state_t r_state;

  // input queue storage and pointers (extra MSB tells full from empty)
  logic [63:0]    r_iq_p  [QDEPTH];
  logic [63:0]    r_iq_o  [QDEPTH];
  logic [IDW-1:0] r_iq_id [QDEPTH];
  logic [QAW:0]   r_iq_wr;
  logic [QAW:0]   r_iq_rd;

  // result queue storage and pointers
  logic [63:0]       r_rq_p  [RDEPTH];
  logic [63:0]       r_rq_o  [RDEPTH];
  logic [IDW-1:0]    r_rq_id [RDEPTH];
  logic signed [7:0] r_rq_s  [RDEPTH];
  logic [RAW:0]      r_rq_wr;
  logic [RAW:0]      r_rq_rd;

  logic [SLOTS-1:0] r_slot_seen;
  logic [PIW:0]     r_inflight;
  logic [CW-1:0]    r_cnt_acc;
  logic [CW-1:0]    r_cnt_done;

  logic             w_run;
  logic             w_iq_empty;
  logic             w_iq_full;
  logic             w_rq_empty;
  logic             w_rq_full;
  logic             w_in_acc;
  logic             w_solve;
  logic             w_show_head;
  logic             w_iq_pop;
  logic             w_rq_push;
  logic             w_rq_pop;
  logic [SLOTS-1:0] w_pidx_oh;
  logic [SLOTS-1:0] w_seen_nxt;
  logic [PIW:0]     w_inflight_nxt;
  logic [QAW-1:0]   w_iq_ra;
  logic [QAW-1:0]   w_iq_wa;
  logic [RAW-1:0]   w_rq_ra;
  logic [RAW-1:0]   w_rq_wa;

  assign w_run = (r_state == S_RUN);

  assign w_iq_ra = r_iq_rd[QAW-1:0];
  assign w_iq_wa = r_iq_wr[QAW-1:0];
  assign w_rq_ra = r_rq_rd[RAW-1:0];
  assign w_rq_wa = r_rq_wr[RAW-1:0];

  assign w_iq_empty = (r_iq_wr == r_iq_rd);
  assign w_iq_full  = (r_iq_wr[QAW] != r_iq_rd[QAW]) &&
                      (w_iq_wa == w_iq_ra);
  assign w_rq_empty = (r_rq_wr == r_rq_rd);
  assign w_rq_full  = (r_rq_wr[RAW] != r_rq_rd[RAW]) &&
                      (w_rq_wa == w_rq_ra);

  // solver freezes while the result queue is full (never in FLUSH)
  assign pl_enable = !w_run || !w_rq_full;
  assign w_solve   = pl_solved && pl_enable;

  // an empty queue or the flush phase presents the dummy task
  assign w_show_head = w_run && !w_iq_empty;
  assign pl_player   = w_show_head ? r_iq_p[w_iq_ra]  : '1;
  assign pl_opponent = w_show_head ? r_iq_o[w_iq_ra]  : '0;
  assign pl_taskid   = w_show_head ? r_iq_id[w_iq_ra] : DUMMY_ID;

  assign w_iq_pop  = w_show_head && w_solve;
  assign w_rq_push = w_run && w_solve && (pl_taskid_o != DUMMY_ID);

  // full test uses the registered count only: a same-cycle pop
  // does not open a slot for the incoming task
  assign in_ready = !w_iq_full;
  assign w_in_acc = in_valid && in_ready;

  assign res_valid    = !w_rq_empty;
  assign res_taskid   = r_rq_id[w_rq_ra];
  assign res_player   = r_rq_p[w_rq_ra];
  assign res_opponent = r_rq_o[w_rq_ra];
  assign res_score    = r_rq_s[w_rq_ra];
  assign w_rq_pop     = res_valid && res_ready;

  assign w_pidx_oh  = SEEN_ONE << pl_pidx;
  assign w_seen_nxt = r_slot_seen | (w_solve ? w_pidx_oh : '0);

  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_iq_pop && !w_rq_push) begin
      w_inflight_nxt = r_inflight + IF_ONE;
    end else if (!w_iq_pop && w_rq_push) begin
      w_inflight_nxt = r_inflight - IF_ONE;
    end
  end

  assign busy = !w_iq_empty || (r_inflight != '0) ||
                !w_rq_empty || !w_run;

  assign inflight     = r_inflight;
  assign cnt_accepted = r_cnt_acc;
  assign cnt_done     = r_cnt_done;

  // queue payload storage; contents are don't-care until written
  always_ff @(posedge iCLOCK) begin
    if (w_in_acc) begin
      r_iq_p[w_iq_wa]  <= in_player;
      r_iq_o[w_iq_wa]  <= in_opponent;
      r_iq_id[w_iq_wa] <= in_taskid;
    end
    if (w_rq_push) begin
      r_rq_p[w_rq_wa]  <= pl_player_o;
      r_rq_o[w_rq_wa]  <= pl_opponent_o;
      r_rq_id[w_rq_wa] <= pl_taskid_o;
      r_rq_s[w_rq_wa]  <= pl_res;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      r_state     <= S_FLUSH;
      r_iq_wr     <= '0;
      r_iq_rd     <= '0;
      r_rq_wr     <= '0;
      r_rq_rd     <= '0;
      r_slot_seen <= '0;
      r_inflight  <= '0;
      r_cnt_acc   <= '0;
      r_cnt_done  <= '0;
    end else begin
      if (w_in_acc) begin
        r_iq_wr   <= r_iq_wr + IQ_ONE;
        r_cnt_acc <= r_cnt_acc + CNT_ONE;
      end
      if (w_iq_pop) begin
        r_iq_rd <= r_iq_rd + IQ_ONE;
      end
      if (w_rq_push) begin
        r_rq_wr    <= r_rq_wr + RQ_ONE;
        r_cnt_done <= r_cnt_done + CNT_ONE;
      end
      if (w_rq_pop) begin
        r_rq_rd <= r_rq_rd + RQ_ONE;
      end
      r_inflight <= w_inflight_nxt;
      unique case (r_state)
        S_FLUSH: begin
          // every slot must report once so stale work is drained
          r_slot_seen <= w_seen_nxt;
          if (&w_seen_nxt) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_state <= S_RUN;
        end
        default: begin
          r_state <= S_FLUSH;
        end
      endcase
    end
  end

endmodule
